// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> little-endian words -> consecutive word writes.
// Optional build macro CHECKSUM_EN adds a trailing 32-bit checksum check (CHK state) before release.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | accepting bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CHK   | receiving the 4-byte checksum (CHECKSUM_EN only)
// DONE  | load finished, entry_pc presented to the core
module imem_loader #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] entry_pc,
  output logic              pc_valid,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef CHECKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t            state, state_nxt;
  logic [1:0]        bcnt;
  logic [31:0]       wbuf, word_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] aligned;
  logic              accept, word_full, start_ok;

  assign aligned   = base_addr & ~ADDR_W'(3);
  assign accept    = byte_valid && byte_ready;
  assign word_full = accept && (bcnt == 2'd3);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    word_nxt = wbuf;
    word_nxt[8*bcnt +: 8] = byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (num_words == '0) ? S_END : S_RECV;
      S_RECV:         if (word_full) state_nxt = S_WRITE;
      S_WRITE:        state_nxt = (remaining == LEN_W'(1)) ? S_END : S_RECV;
`ifdef CHECKSUM_EN
      S_CHK:          if (word_full) state_nxt = S_DONE;
`endif
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      S_RECV:  begin byte_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin mem_wr_en  = 1'b1; busy = 1'b1; end
`ifdef CHECKSUM_EN
      S_CHK:   begin byte_ready = 1'b1; busy = 1'b1; end
`endif
      default: ;
    endcase
  end

`ifdef CHECKSUM_EN
  logic [31:0] sum;
  logic        err_q;
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (start_ok) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_WRITE) sum <= sum + mem_wdata;
      if (word_full && (state == S_CHK)) err_q <= (word_nxt != sum);
    end
  end
`else
  assign err = 1'b0;
`endif

  // Datapath; mem_addr/mem_wdata are captured on the last byte so they hold after WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt      <= '0;
      wbuf      <= '0;
      addr      <= '0;
      remaining <= '0;
      entry_pc  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      pc_valid  <= 1'b0;
    end else if (start_ok) begin
      bcnt      <= '0;
      addr      <= aligned;
      entry_pc  <= aligned;
      remaining <= num_words;
      done      <= 1'b0;
      pc_valid  <= 1'b0;
    end else begin
      if (accept) begin
        bcnt <= bcnt + 2'd1;
        wbuf <= word_nxt;
      end
      if (word_full && (state == S_RECV)) begin
        mem_addr  <= addr;
        mem_wdata <= word_nxt;
      end
      if (state == S_WRITE) begin
        addr      <= addr + ADDR_W'(4);
        remaining <= remaining - LEN_W'(1);
      end
      if (state == S_DONE) begin
        done     <= 1'b1;
        pc_valid <= ~err;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for instruction memory, feeding the same word-addressed memory that the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake.
- Assembles bytes into little-endian 32-bit instruction words.
- Writes each word to consecutive word addresses starting at a programmable entry point.
- Releases the core by presenting the entry PC once the load completes.

Parameters:
LEN_W, 16, width of the word-count input; max load = 2^LEN_W - 1 words
ADDR_W, 32, width of memory address and PC

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: begin a load (honoured only in IDLE or DONE)
base_addr  input  ADDR_W  entry point / first write address, sampled on start
num_words  input  LEN_W  number of instruction words to load, sampled on start
byte_valid  input  1  upstream byte present
byte_data  input  8  upstream byte
byte_ready  output  1  loader can accept a byte this cycle
mem_wr_en  output  1  one-cycle instruction-memory write strobe
mem_addr  output  ADDR_W  write address (word aligned)
mem_wdata  output  32  write data
busy  output  1  load in progress
done  output  1  load complete, held until next start or rst
entry_pc  output  ADDR_W  PC the core starts fetching from
pc_valid  output  1  entry_pc valid; core may begin fetch
err  output  1  checksum mismatch (see Optional Feature; 0 otherwise)

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0; byte_ready=0.
  - Internal byte counter, word buffer, address and remaining-count cleared.
  - Any partially received word is discarded; reset mid-load has no further memory writes.
- States: IDLE, RECV, WRITE, CHK (only with the feature), DONE.
- IDLE/DONE + start=1:
  - Latch aligned base = {base_addr[ADDR_W-1:2], 2'b00} into the address register and into entry_pc.
  - Latch num_words; clear done, pc_valid and err.
  - If num_words==0, go to DONE next cycle; otherwise go to RECV.
- start is ignored in RECV, WRITE and CHK.
- RECV:
  - byte_ready=1, busy=1.
  - A byte transfers when byte_valid && byte_ready at the clock edge.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k]; byte 0 is the LSB.
  - After the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_wr_en=1; mem_addr = current address; mem_wdata = assembled word; byte_ready=0.
  - Next cycle: address += 4 (mod 2^ADDR_W wrap, no error); remaining -= 1.
  - If remaining reaches 0, go to DONE (or CHK with the feature); else go to RECV.
- Throughput: at most 4 bytes per 5 cycles; one-cycle bubble per word.
- mem_wr_en is 0 in every state except WRITE.
- mem_addr and mem_wdata hold their last values when mem_wr_en=0.
- DONE:
  - busy=0, done=1, pc_valid=1.
  - entry_pc = aligned base.
  - byte_ready=0; incoming bytes are not consumed.
- start asserted together with a final byte transfer: the start is ignored (state is RECV).
- Simultaneous rst and start: rst wins.

Optional Feature:
CHECKSUM_EN:
- Defined:
  - After the last WRITE, enter CHK with byte_ready=1.
  - Receive 4 more bytes (little-endian) as a checksum; these are not written to memory.
  - Compare against the running 32-bit modulo sum of all written words.
  - Mismatch: err=1, pc_valid stays 0.
  - Match: err=0, pc_valid=1.
  - Either way, go to DONE and set done=1.
  - With num_words==0, CHK still runs; the expected sum is 0.
- Undefined: no CHK state, err tied 0, pc_valid=1 in DONE.

Test Plan:
- Reset mid-load: rst at cycle 10 after start → all outputs 0, state IDLE, no further mem_wr_en.
- Basic load:
  - Stimulus: base_addr=128, num_words=3, bytes 13 00 08 20 | 0a 00 09 20 | 20 50 09 01.
  - Response: writes (128,0x20080013), (132,0x2009000a), (136,0x01095020); then done=1, pc_valid=1, entry_pc=128.
- Upstream stalls: byte_valid toggled 1/0 every cycle, base_addr=0x83, num_words=2 → first write at address 0x80; second write at 0x84 with correct data; ready low during WRITE.
- Zero-length and restart:
  - num_words=0 → done=1 two cycles after start, no writes.
  - Second start with base 0x200, 1 word → done clears, write at 0x200, done re-asserts.
- Address wrap: base 0xFFFFFFFC, num_words=2 → writes at 0xFFFFFFFC then 0x00000000.
- Checksum (CHECKSUM_EN): words 1,2 plus checksum 03 00 00 00 → err=0, pc_valid=1; checksum 04 00 00 00 → err=1, pc_valid=0.
